// File: rtl/core_if_id_pkg.sv
// Shared constants and state encoding for the IF/ID pipeline register.
package core_if_id_pkg;

    localparam int InstByteBus    = 32;
    localparam int InstAddressBus = 32;

    localparam logic [InstByteBus-1:0]    InstNop  = 32'h0000_0013;
    localparam logic [InstAddressBus-1:0] ZeroWord = 32'h0000_0000;

    typedef enum logic [1:0] {
        IfIdBoot   = 2'd0,
        IfIdRun    = 2'd1,
        IfIdSquash = 2'd2
    } if_id_state_e;

endpackage

// File: rtl/core_if_id.sv
// IF/ID pipeline register: latches fetched words, honours hold, and issues
// NOP bubbles after reset and after a flush while counting them.
module core_if_id
    import core_if_id_pkg::*;
#(
    parameter int RESET_BUBBLES = 1,
    parameter int FLUSH_BUBBLES = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [InstByteBus-1:0]    inst_in,
    input  logic [InstAddressBus-1:0] inst_addr_in,
    input  logic                      hold_in,
    input  logic                      flush_in,
    output logic [InstByteBus-1:0]    inst_out,
    output logic [InstAddressBus-1:0] inst_addr_out,
    output logic                      inst_valid_out,
    output logic [15:0]               bubble_cnt_out
);

    localparam if_id_state_e RST_STATE = (RESET_BUBBLES > 0) ? IfIdBoot : IfIdRun;
    localparam logic [2:0]   RST_CNT   = (RESET_BUBBLES > 0) ? 3'(RESET_BUBBLES - 1) : 3'd0;
    localparam if_id_state_e FL_STATE  = (FLUSH_BUBBLES > 0) ? IfIdSquash : IfIdRun;
    localparam logic [2:0]   FL_CNT    = (FLUSH_BUBBLES > 0) ? 3'(FLUSH_BUBBLES - 1) : 3'd0;

    if_id_state_e               r_state;
    logic [2:0]                 r_cnt;
    logic [InstByteBus-1:0]     r_inst_p1;
    logic [InstAddressBus-1:0]  r_addr_p1;
    logic                       r_vld_p1;
    logic [15:0]                r_bub_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

    // Fetch -> decode boundary
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RST_STATE;
            r_cnt     <= RST_CNT;
            r_inst_p1 <= InstNop;
            r_addr_p1 <= ZeroWord;
            r_vld_p1  <= 1'b0;
            r_bub_cnt <= 16'd0;
        end else if (flush_in) begin
            r_inst_p1 <= InstNop;
            r_addr_p1 <= ZeroWord;
            r_vld_p1  <= 1'b0;
            r_bub_cnt <= sat_inc(r_bub_cnt);
            r_state   <= FL_STATE;
            r_cnt     <= FL_CNT;
        end else if (!hold_in) begin
            case (r_state)
                IfIdRun: begin
                    r_inst_p1 <= inst_in;
                    r_addr_p1 <= inst_addr_in;
                    r_vld_p1  <= 1'b1;
                end
                IfIdBoot, IfIdSquash: begin
                    r_inst_p1 <= InstNop;
                    r_addr_p1 <= ZeroWord;
                    r_vld_p1  <= 1'b0;
                    r_bub_cnt <= sat_inc(r_bub_cnt);
                    if (r_cnt == 3'd0) begin
                        r_state <= IfIdRun;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: r_state <= IfIdRun;
            endcase
        end
    end

    assign inst_out       = r_inst_p1;
    assign inst_addr_out  = r_addr_p1;
    assign inst_valid_out = r_vld_p1;
    assign bubble_cnt_out = r_bub_cnt;

endmodule
